uart_tx: RTL
============

Name: uart_tx

Overview:
Serial UART transmitter: 8N1 framing by default, 1 start bit, 8 data bits LSB first, STOP_BITS stop bits, idle-high line.
- Companion to the team's UART receiver, with matching CLKS_PER_BIT timing, so TX→RX loopback works directly.
- Accepts one byte per frame through a valid/ready handshake from the host-side logic.
- Drives the serial pin from a flop.

Parameters:
CLKS_PER_BIT, 87, clock cycles per serial bit; legal range ≥2.
STOP_BITS, 1, number of stop bits; legal values 1 or 2.
PARITY_ODD, 0, parity sense when parity is compiled in: 0 = even, 1 = odd.

Ports:
i_Clock  input  1  system clock, rising-edge.
i_Rst_L  input  1  asynchronous active-low reset.
i_TX_DV  input  1  byte valid; transfer occurs on an edge where i_TX_DV && o_TX_Ready.
i_TX_Byte  input  8  byte to send; sampled only on the transfer edge.
o_TX_Ready  output  1  high in IDLE only; block can accept a byte.
o_TX_Active  output  1  high from first start-bit cycle through last stop-bit cycle.
o_TX_Serial  output  1  serial line, registered, idle 1.
o_TX_Done  output  1  one-cycle pulse after the last stop bit completes.

Behaviour:
- Reset (asynchronous, immediate):
  - state=IDLE, o_TX_Serial=1, o_TX_Ready=1.
  - o_TX_Active=0, o_TX_Done=0.
  - Counters and shift register cleared.
  - Reset mid-frame aborts the frame; line returns high at once; no Done pulse.
- Bit-timing counter: width $clog2(CLKS_PER_BIT); counts 0..CLKS_PER_BIT-1; each bit held exactly CLKS_PER_BIT cycles.
- IDLE:
  - o_TX_Serial=1, Ready=1.
  - On transfer edge: latch i_TX_Byte into the shift register, serial←0, Active←1, Ready←0, go to TX_START_BIT.
- TX_START_BIT: serial=0 for CLKS_PER_BIT cycles, then go to TX_DATA_BITS with bit index 0.
- TX_DATA_BITS:
  - Serial = byte[index] for CLKS_PER_BIT cycles per bit, index 0..7.
  - After bit 7, go to TX_PARITY_BIT if compiled in, else TX_STOP_BIT.
- TX_STOP_BIT: serial=1 for STOP_BITS*CLKS_PER_BIT cycles, then go to CLEANUP.
- CLEANUP (1 cycle):
  - Active=0, Done=1, serial=1, Ready=0.
  - Next cycle: IDLE, Done=0, Ready=1.
- Timing:
  - Start bit begins on the edge after the transfer edge.
  - Minimum start-to-start spacing = (9+STOP_BITS[+1 parity])*CLKS_PER_BIT + 2 cycles.
- i_TX_DV while Ready=0 is ignored; it is not queued.
- i_TX_Byte changes during a frame have no effect.
- Illegal state encodings recover to IDLE with serial=1.

Optional Feature:
Macro UART_TX_PARITY_EN.
- Defined:
  - Adds state TX_PARITY_BIT between data and stop, lasting CLKS_PER_BIT cycles.
  - Parity bit value = ^byte XOR PARITY_ODD.
  - Frame length grows by one bit.
- Undefined: no parity state or logic; PARITY_ODD is unused; frame is 8N(STOP_BITS).

Decomposition:
- Shared package uart_pkg:
  - State encoding constants: IDLE, TX_START_BIT, TX_DATA_BITS, TX_PARITY_BIT, TX_STOP_BIT, CLEANUP (3-bit).
  - Data width constant 8.
  - Function for counter width.
  - Package is also usable by the receiver.
- One natural sub-module, uart_baud_cnt:
  - Bit-period counter with load/clear and a terminal-count pulse.
  - Parameterised by CLKS_PER_BIT.
  - Reusable by the RX side.

Test Plan:
- CLKS_PER_BIT=4, STOP_BITS=1:
  - Send 0xA5 → serial 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles.
  - Active high 40 cycles; Done pulses once on cycle 41 after start; Ready returns the cycle after.
- Back-to-back, i_TX_DV held high with 0x00 then 0xFF → second start bit begins exactly 42 cycles after the first; both frames bit-exact.
- i_TX_DV pulsed with 0x3C during a frame; i_TX_Byte toggled → both ignored; in-flight frame unchanged; no second frame.
- Assert i_Rst_L low during data bit 3 → o_TX_Serial=1 and Ready=1 immediately; Active=0; no Done; next byte 0x81 sent correctly.
- STOP_BITS=2, send 0x55 → stop phase 8 cycles high; total Active 44 cycles.
- UART_TX_PARITY_EN defined, 0xA5 (four 1s):
  - PARITY_ODD=0 → parity bit 0; PARITY_ODD=1 → parity bit 1.
  - Loopback into the team receiver built with matching CLKS_PER_BIT=87 → 0x00, 0x5A, 0xFF all recovered with o_RX_DV.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, data width and counter sizing.
// Used by both the transmitter and the receiver side.
package uart_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE          = 3'd0,
        TX_START_BIT  = 3'd1,
        TX_DATA_BITS  = 3'd2,
        TX_PARITY_BIT = 3'd3,
        TX_STOP_BIT   = 3'd4,
        CLEANUP       = 3'd5
    } uart_state_e;

    // Width of a counter that must hold 0..clks-1 (never narrower than one bit).
    function automatic int cnt_width(input int clks);
        return (clks <= 2) ? 1 : $clog2(clks);
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: runs 0..CLKS_PER_BIT-1 and wraps, pulsing tc_o on the
// last cycle of each bit. Holding clr_i loads zero so the first bit after a
// clear is a full period. Shared between TX and RX.
module uart_baud_cnt
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 87
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    output logic tc_o
);

    localparam int                W    = cnt_width(CLKS_PER_BIT);
    localparam logic [W-1:0]      LAST = W'(CLKS_PER_BIT - 1);

    logic [W-1:0] cnt_q, cnt_d;

    assign tc_o = !clr_i && (cnt_q == LAST);

    // Next count: wrap at terminal count, zero while cleared.
    always_comb begin
        cnt_d = cnt_q + W'(1);
        if (clr_i || tc_o) cnt_d = '0;
    end

    // Count register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: 1 start bit, 8 data bits LSB first, optional parity,
// STOP_BITS stop bits, idle-high line driven straight from a flop.
// Define UART_TX_PARITY_EN to insert a parity bit (sense set by PARITY_ODD).
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 87,
    parameter int STOP_BITS    = 1,
    parameter bit PARITY_ODD   = 1'b0
) (
    input  logic              i_Clock,
    input  logic              i_Rst_L,
    input  logic              i_TX_DV,
    input  logic [DATA_W-1:0] i_TX_Byte,
    output logic              o_TX_Ready,
    output logic              o_TX_Active,
    output logic              o_TX_Serial,
    output logic              o_TX_Done
);

    uart_state_e       state_q, state_d;
    logic [2:0]        idx_q, idx_d;      // data bit index, reused for stop bits
    logic [DATA_W-1:0] shreg_q, shreg_d;  // LSB is the bit on the line
    logic              serial_q, serial_d;
    logic              bit_tc;
`ifdef UART_TX_PARITY_EN
    logic              par_q, par_d;
`endif

    // Counter idles at zero outside a frame so every bit gets a full period.
    uart_baud_cnt #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk_i (i_Clock),
        .rst_ni(i_Rst_L),
        .clr_i (!o_TX_Active),
        .tc_o  (bit_tc)
    );

    // State and datapath registers; reset aborts any frame with the line high.
    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            shreg_q  <= '0;
            serial_q <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            shreg_q  <= shreg_d;
            serial_q <= serial_d;
`ifdef UART_TX_PARITY_EN
            par_q    <= par_d;
`endif
        end
    end

    // Next-state: advance one bit per terminal count; bytes accepted only in IDLE.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        shreg_d = shreg_q;
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            IDLE: begin
                if (i_TX_DV) begin
                    state_d = TX_START_BIT;
                    shreg_d = i_TX_Byte;
                    idx_d   = '0;
`ifdef UART_TX_PARITY_EN
                    par_d   = (^i_TX_Byte) ^ PARITY_ODD;
`endif
                end
            end
            TX_START_BIT: begin
                if (bit_tc) state_d = TX_DATA_BITS;
            end
            TX_DATA_BITS: begin
                if (bit_tc) begin
                    shreg_d = shreg_q >> 1;
                    if (idx_q == 3'd7) begin
                        idx_d   = '0;
`ifdef UART_TX_PARITY_EN
                        state_d = TX_PARITY_BIT;
`else
                        state_d = TX_STOP_BIT;
`endif
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            TX_PARITY_BIT: begin
                if (bit_tc) state_d = TX_STOP_BIT;
            end
`endif
            TX_STOP_BIT: begin
                if (bit_tc) begin
                    if (idx_q == 3'(STOP_BITS - 1)) begin
                        idx_d   = '0;
                        state_d = CLEANUP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            CLEANUP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs: status decoded from the current state, line level from the next.
    always_comb begin
        o_TX_Ready  = 1'b0;
        o_TX_Active = 1'b0;
        o_TX_Done   = 1'b0;
        case (state_q)
            IDLE:         o_TX_Ready  = 1'b1;
            TX_START_BIT,
            TX_DATA_BITS,
`ifdef UART_TX_PARITY_EN
            TX_PARITY_BIT,
`endif
            TX_STOP_BIT:  o_TX_Active = 1'b1;
            CLEANUP:      o_TX_Done   = 1'b1;
            default:      ;
        endcase

        case (state_d)
            TX_START_BIT:  serial_d = 1'b0;
            TX_DATA_BITS:  serial_d = shreg_d[0];
`ifdef UART_TX_PARITY_EN
            TX_PARITY_BIT: serial_d = par_d;
`endif
            default:       serial_d = 1'b1;
        endcase
    end

    assign o_TX_Serial = serial_q;

endmodule
